// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, default dimensions and width helper for matmul_ctrl
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_ACCUM = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_M_DIM = 2;
  localparam int DEF_N_DIM = 2;
  localparam int DEF_K_DIM = 8;

  // Bits needed to index 'depth' entries; never less than one bit.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// rtl/matmul_index_counter.sv - nested k/j/i loop counters with last-flags
module matmul_index_counter
  import matmul_pkg::*;
#(
  parameter int M_DIM = DEF_M_DIM,
  parameter int N_DIM = DEF_N_DIM,
  parameter int K_DIM = DEF_K_DIM
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_k_en,
  input  logic                        i_elem_adv,
  output logic [addr_w(K_DIM)-1:0]    o_k,
  output logic [addr_w(N_DIM)-1:0]    o_j,
  output logic [addr_w(M_DIM)-1:0]    o_i,
  output logic                        o_k_last,
  output logic                        o_elem_last
);

  localparam int KW = addr_w(K_DIM);
  localparam int JW = addr_w(N_DIM);
  localparam int IW = addr_w(M_DIM);

  logic [KW-1:0] r_k;
  logic [JW-1:0] r_j;
  logic [IW-1:0] r_i;
  logic          w_j_last;
  logic          w_i_last;

  assign w_j_last    = (r_j == JW'(N_DIM - 1));
  assign w_i_last    = (r_i == IW'(M_DIM - 1));
  assign o_k_last    = (r_k == KW'(K_DIM - 1));
  assign o_elem_last = w_j_last && w_i_last;
  assign o_k         = r_k;
  assign o_j         = r_j;
  assign o_i         = r_i;

  // k steps per MAC cycle; j/i step once per stored element, j innermost.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_k <= '0;
      r_j <= '0;
      r_i <= '0;
    end else begin
      if (i_k_en) begin
        r_k <= o_k_last ? '0 : r_k + KW'(1);
      end
      if (i_elem_adv) begin
        if (w_j_last) begin
          r_j <= '0;
          r_i <= w_i_last ? '0 : r_i + IW'(1);
        end else begin
          r_j <= r_j + JW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - C=A*B sequencer for one MAC unit; stall input enabled by MATMUL_CTRL_STALL_EN
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int M_DIM = DEF_M_DIM,
  parameter int N_DIM = DEF_N_DIM,
  parameter int K_DIM = DEF_K_DIM
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_start,
`ifdef MATMUL_CTRL_STALL_EN
  input  logic                              i_stall,
`endif
  output logic [addr_w(M_DIM*K_DIM)-1:0]    o_a_addr,
  output logic [addr_w(K_DIM*N_DIM)-1:0]    o_b_addr,
  output logic [addr_w(M_DIM*N_DIM)-1:0]    o_c_addr,
  output logic                              o_mac_clear,
  output logic                              o_mac_en,
  output logic                              o_add,
  output logic                              o_c_we,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int AAW = addr_w(M_DIM * K_DIM);
  localparam int BAW = addr_w(K_DIM * N_DIM);
  localparam int CAW = addr_w(M_DIM * N_DIM);

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_stall;
  logic                      w_clear;
  logic                      w_k_en;
  logic                      w_elem_adv;
  logic [addr_w(K_DIM)-1:0]  w_k;
  logic [addr_w(N_DIM)-1:0]  w_j;
  logic [addr_w(M_DIM)-1:0]  w_i;
  logic                      w_k_last;
  logic                      w_elem_last;

`ifdef MATMUL_CTRL_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  matmul_index_counter #(
    .M_DIM (M_DIM),
    .N_DIM (N_DIM),
    .K_DIM (K_DIM)
  ) u_index (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_k_en      (w_k_en),
    .i_elem_adv  (w_elem_adv),
    .o_k         (w_k),
    .o_j         (w_j),
    .o_i         (w_i),
    .o_k_last    (w_k_last),
    .o_elem_last (w_elem_last)
  );

  // Row-major operand/result indices straight from the loop counters.
  assign o_a_addr = AAW'(int'(w_i) * K_DIM + int'(w_k));
  assign o_b_addr = BAW'(int'(w_k) * N_DIM + int'(w_j));
  assign o_c_addr = CAW'(int'(w_i) * N_DIM + int'(w_j));

  // State register; reset abandons any run in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, counter control and state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_k_en      = 1'b0;
    w_elem_adv  = 1'b0;
    o_mac_clear = 1'b0;
    o_mac_en    = 1'b0;
    o_add       = 1'b0;
    o_c_we      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = ST_MAC;
        end
      end
      ST_MAC: begin
        o_busy = 1'b1;
        if (!w_stall) begin
          o_mac_en    = 1'b1;
          o_mac_clear = (w_k == '0);
          w_k_en      = 1'b1;
          if (w_k_last) begin
            w_next = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        o_busy = 1'b1;
        o_add  = 1'b1;
        w_next = ST_STORE;
      end
      ST_STORE: begin
        o_busy = 1'b1;
        o_c_we = 1'b1;
        if (w_elem_last) begin
          w_next = ST_DONE;
        end else begin
          w_elem_adv = 1'b1;
          w_next     = ST_MAC;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        w_clear = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Parametrised sequencer for the matrix-multiply datapath: computes C[M×N] = A[M×K] · B[K×N] one output element at a time on a single MAC unit. It drives operand addresses, MAC clear/enable, the accumulate strobe and result write-back, and exposes a start/busy/done handshake to the host. It replaces the fixed 8-entry multiply/accumulate/store controller with arbitrary dimensions, full address generation and an optional stall input.

## Interface
- M_DIM, 2: rows of A and C (≥1)
- N_DIM, 2: columns of B and C (≥1)
- K_DIM, 8: inner dimension, MAC cycles per element (≥1)
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; forces IDLE and clears all counters
- start  in  1  request a full multiply; sampled only in IDLE
- stall  in  1  operand not ready; freezes MAC phase (only with MATMUL_CTRL_STALL_EN)
- a_addr  out  $clog2(M_DIM*K_DIM) (min 1)  A index, row-major: i*K_DIM+k
- b_addr  out  $clog2(K_DIM*N_DIM) (min 1)  B index, row-major: k*N_DIM+j
- c_addr  out  $clog2(M_DIM*N_DIM) (min 1)  C index, row-major: i*N_DIM+j
- mac_clear  out  1  zero the accumulator before the product (k==0 MAC cycle)
- mac_en  out  1  multiply-accumulate this cycle
- add  out  1  final accumulate/round cycle
- c_we  out  1  write accumulator to c_addr
- busy  out  1  high in MAC, ACCUM, STORE
- done  out  1  one-cycle pulse when whole matrix complete

## Operation
- States: IDLE, MAC, ACCUM, STORE, DONE (encoding in package).
- IDLE: start=1 → MAC with i=j=k=0; else stay. start ignored in all other states.
- MAC: mac_en=1 (0 while stalled); mac_clear=1 when k==0 and not stalled. k increments each unstalled cycle; on unstalled k==K_DIM-1 → ACCUM, k←0.
- ACCUM: add=1, one cycle → STORE.
- STORE: c_we=1 with c_addr=i*N_DIM+j, one cycle. If i==M_DIM-1 and j==N_DIM-1 → DONE; else j increments (wraps to 0 with i increment) → MAC.
- DONE: done=1, one cycle → IDLE; counters cleared.
- Addresses are combinational from registered counters; hold their value outside MAC. All other outputs decoded from state (Moore), no latches; every case has a default.
- Reset (any state, incl. mid-multiply): next cycle IDLE, i=j=k=0, all outputs 0, addresses 0. Partial results are abandoned; no done pulse.
- K_DIM=1: each MAC cycle asserts mac_clear and mac_en together.
- Stall outside MAC has no effect; stall in the same cycle as k==K_DIM-1 holds k and state.

## Timing
- Reset values: all outputs 0, state IDLE.
- First MAC cycle is the cycle after start is sampled.
- Per element: K_DIM+2 cycles unstalled; total MAC..STORE span M_DIM*N_DIM*(K_DIM+2) cycles, then one DONE cycle. Defaults: 40 cycles busy, done in cycle 41 after start edge.
- Each stalled cycle adds exactly one cycle of latency.
- Earliest restart: start high in the cycle after DONE (IDLE) is accepted; back-to-back start held high produces a new run with one IDLE cycle between done and next busy.

## Configuration
- MATMUL_CTRL_STALL_EN defined: stall port present, behaves as above.
- Undefined: stall port absent, treated internally as 0; timing is fixed at the unstalled figures.

## Structure
- matmul_pkg: state enum (IDLE, MAC, ACCUM, STORE, DONE), default dimension constants, address-width helper function.
- One sub-module: matmul_index_counter — nested k/j/i counters with enable, clear and last-flags (k_last, elem_last); controller FSM instantiates it once.

## Test plan
- Reset mid-MAC (default dims, cycle 10 after start) → next cycle IDLE, busy=0, addresses 0, no done; subsequent start runs full 40 cycles.
- Default 2×2×8, start one cycle → busy 40 cycles, c_we at c_addr 0,1,2,3 in cycles 10,20,30,40, done pulse cycle 41.
- M=3,N=2,K=1 → each element 3 cycles with mac_clear&mac_en together; a_addr sequence 0,0,1,1,2,2; done after 18 busy cycles.
- Stall (macro on) 3 cycles at k=4 of element 0 → k, a_addr, b_addr hold, mac_en=0; done arrives 3 cycles late (cycle 44).
- start held high through DONE → second run begins after one IDLE cycle; start pulses during busy ignored.
- Address check 2×3×4: element (1,2) uses a_addr 4..7, b_addr 2,5,8,11, c_addr 5.
